// File: rtl/miner_job_master_if.sv
// Job handshake, miner-slave register bus and result signals of miner_job_master.
interface miner_job_master_if;
    logic         job_valid;
    logic         job_ready;
    logic [607:0] job_msg;
    logic [255:0] job_target;
    logic         abort;
    logic [4:0]   mst_address;
    logic [31:0]  mst_writedata;
    logic         mst_write;
    logic         mst_read;
    logic         mst_chipselect;
    logic [31:0]  mst_readdata;
    logic         busy;
    logic         result_valid;
    logic         result_found;
    logic [31:0]  result_nonce;

    modport master (
        input  job_valid, job_msg, job_target, abort, mst_readdata,
        output job_ready, mst_address, mst_writedata, mst_write, mst_read,
               mst_chipselect, busy, result_valid, result_found, result_nonce
    );

    modport slave (
        output job_valid, job_msg, job_target, abort, mst_readdata,
        input  job_ready, mst_address, mst_writedata, mst_write, mst_read,
               mst_chipselect, busy, result_valid, result_found, result_nonce
    );
endinterface

// File: rtl/miner_job_master.sv
// Loads a mining job into the miner slave, polls its status and reports the
// winning nonce. Bus outputs are a pure function of state and word index.
module miner_job_master #(
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned RD_LAT   = 1
) (
    input logic               clk,
    input logic               rst,
    miner_job_master_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, WR_TGT, WR_MSG, CTRL0, CTRL1, CTRL3, POLL_WAIT,
        RD_STAT, STAT_WAIT, RD_NONCE, NONCE_WAIT, REPORT
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  word_idx;
    logic [7:0]  gap_cnt;
    logic [1:0]  lat_cnt;
    logic [31:0] tgt_q [8];
    logic [31:0] msg_q [19];
    logic        found_q;
    logic [31:0] nonce_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state != IDLE && bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:       if (bus.job_valid) state_next = WR_TGT;
                WR_TGT:     if (word_idx == 5'd7) state_next = WR_MSG;
                WR_MSG:     if (word_idx == 5'd18) state_next = CTRL0;
                CTRL0:      state_next = CTRL1;
                CTRL1:      state_next = CTRL3;
                CTRL3:      state_next = POLL_WAIT;
                POLL_WAIT:  if (gap_cnt == '0) state_next = RD_STAT;
                RD_STAT:    state_next = STAT_WAIT;
                STAT_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (!bus.mst_readdata[1])    state_next = POLL_WAIT;
                        else if (bus.mst_readdata[0]) state_next = RD_NONCE;
                        else                          state_next = REPORT;
                    end
                end
                RD_NONCE:   state_next = NONCE_WAIT;
                NONCE_WAIT: if (lat_cnt == '0) state_next = REPORT;
                REPORT:     state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Counters reload on state entry, so an abort leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
            gap_cnt  <= '0;
            lat_cnt  <= '0;
            found_q  <= 1'b0;
            nonce_q  <= '0;
        end else begin
            if ((state == WR_TGT || state == WR_MSG) && state_next == state)
                word_idx <= word_idx + 5'd1;
            else
                word_idx <= '0;

            if (state_next == POLL_WAIT)
                gap_cnt <= (state == POLL_WAIT) ? gap_cnt - 8'd1 : GAP_LOAD;
            else
                gap_cnt <= '0;

            if (state_next == STAT_WAIT || state_next == NONCE_WAIT)
                lat_cnt <= (state == state_next) ? lat_cnt - 2'd1 : LAT_LOAD;
            else
                lat_cnt <= '0;

            if (state == STAT_WAIT && state_next == REPORT) begin
                found_q <= 1'b0;
                nonce_q <= '0;
            end else if (state == NONCE_WAIT && state_next == REPORT) begin
                found_q <= 1'b1;
                nonce_q <= bus.mst_readdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.job_valid) begin
            for (int unsigned i = 0; i < 8; i++)
                tgt_q[i] <= bus.job_target[32*i +: 32];
            for (int unsigned i = 0; i < 19; i++)
                msg_q[i] <= bus.job_msg[32*i +: 32];
        end
    end

    always_comb begin
        bus.job_ready      = (state == IDLE);
        bus.busy           = (state != IDLE);
        bus.result_valid   = (state == REPORT);
        bus.result_found   = found_q;
        bus.result_nonce   = nonce_q;
        bus.mst_address    = '0;
        bus.mst_writedata  = '0;
        bus.mst_write      = 1'b0;
        bus.mst_read       = 1'b0;
        bus.mst_chipselect = 1'b0;
        case (state)
            WR_TGT: begin
                bus.mst_chipselect = 1'b1;
                bus.mst_write      = 1'b1;
                bus.mst_address    = 5'd2 + word_idx;
                bus.mst_writedata  = tgt_q[word_idx[2:0]];
            end
            WR_MSG: begin
                bus.mst_chipselect = 1'b1;
                bus.mst_write      = 1'b1;
                bus.mst_address    = 5'd11 + word_idx;
                bus.mst_writedata  = msg_q[word_idx];
            end
            CTRL0, CTRL1, CTRL3: begin
                bus.mst_chipselect = 1'b1;
                bus.mst_write      = 1'b1;
                bus.mst_address    = 5'd1;
                bus.mst_writedata  = (state == CTRL0) ? 32'd0 :
                                     (state == CTRL1) ? 32'd1 : 32'd3;
            end
            RD_STAT: begin
                bus.mst_chipselect = 1'b1;
                bus.mst_read       = 1'b1;
                bus.mst_address    = 5'd31;
            end
            RD_NONCE: begin
                bus.mst_chipselect = 1'b1;
                bus.mst_read       = 1'b1;
                bus.mst_address    = 5'd30;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_miner_job_master.sv
// Scoreboard bench for miner_job_master: stimulus queues expected bus accesses
// and results with their exact cycle; monitors pop and compare on every access.
module tb_miner_job_master;

    localparam int unsigned G = 1;
    localparam int unsigned L = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miner_job_master_if bus();

    miner_job_master #(.POLL_GAP(G), .RD_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic wr; logic [4:0] addr; logic [31:0] data; int at; } acc_t;
    typedef struct { logic found; logic [31:0] nonce; int at; } res_t;
    typedef struct { int due; logic [31:0] data; } pend_t;

    acc_t        exp_bus[$];
    res_t        exp_res[$];
    logic [31:0] resp_q[$];
    pend_t       pend_q[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Bus and result monitor
    acc_t mon_e;
    res_t mon_r;
    always @(negedge clk) begin
        if (bus.mst_chipselect || bus.mst_write || bus.mst_read) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got access addr %0d wr %0b rd %0b expected none (cycle %0d)",
                         bus.mst_address, bus.mst_write, bus.mst_read, cyc);
            end else begin
                mon_e = exp_bus.pop_front();
                chk("bus_cs", 64'(bus.mst_chipselect), 64'd1);
                chk("bus_strobe", 64'({bus.mst_write, bus.mst_read}), mon_e.wr ? 64'd2 : 64'd1);
                chk("bus_addr", 64'(bus.mst_address), 64'(mon_e.addr));
                if (mon_e.wr) chk("bus_wdata", 64'(bus.mst_writedata), 64'(mon_e.data));
                chk("bus_cycle", 64'(cyc), 64'(mon_e.at));
            end
        end
        if (bus.result_valid) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got result_valid expected none (cycle %0d)", cyc);
            end else begin
                mon_r = exp_res.pop_front();
                chk("res_found", 64'(bus.result_found), 64'(mon_r.found));
                chk("res_nonce", 64'(bus.result_nonce), 64'(mon_r.nonce));
                chk("res_cycle", 64'(cyc), 64'(mon_r.at));
            end
        end
    end

    // Miner slave: read data is valid only in the cycle RD_LAT after the strobe
    pend_t sl_p;
    always @(negedge clk) begin
        if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
            sl_p = pend_q.pop_front();
            bus.mst_readdata = sl_p.data;
        end else begin
            bus.mst_readdata = 32'hDEAD_0000;
        end
        if (bus.mst_read) begin
            sl_p.due  = cyc + int'(L);
            sl_p.data = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
            pend_q.push_back(sl_p);
        end
    end

    function automatic logic [607:0] mk_msg(input logic [31:0] base, input logic [31:0] step);
        logic [607:0] m;
        for (int i = 0; i < 19; i++) m[32*i +: 32] = base + step * 32'(i);
        return m;
    endfunction

    function automatic logic [255:0] mk_tgt(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = base + step * 32'(i);
        return t;
    endfunction

    task automatic start_job(input logic [255:0] t, input logic [607:0] m, input int nw,
                             input int nstat, input logic found, input logic [31:0] nonce,
                             output int h);
        acc_t a;
        res_t r;
        int   r0;
        int   rl;
        @(negedge clk);
        bus.job_target = t;
        bus.job_msg    = m;
        bus.job_valid  = 1'b1;
        h = cyc;
        chk("job_ready_offer", 64'(bus.job_ready), 64'd1);
        for (int k = 0; k < nw; k++) begin
            a.wr = 1'b1;
            a.at = h + 1 + k;
            if (k < 8) begin
                a.addr = 5'(2 + k);
                a.data = t[32*k +: 32];
            end else if (k < 27) begin
                a.addr = 5'(11 + k - 8);
                a.data = m[32*(k-8) +: 32];
            end else begin
                a.addr = 5'd1;
                a.data = (k == 27) ? 32'd0 : (k == 28) ? 32'd1 : 32'd3;
            end
            exp_bus.push_back(a);
        end
        if (nstat > 0) begin
            r0 = h + 31 + int'(G);
            for (int i = 0; i < nstat; i++) begin
                a.wr = 1'b0; a.addr = 5'd31; a.data = '0;
                a.at = r0 + i * int'(1 + L + G);
                exp_bus.push_back(a);
            end
            rl = r0 + (nstat - 1) * int'(1 + L + G);
            if (found) begin
                a.wr = 1'b0; a.addr = 5'd30; a.data = '0; a.at = rl + int'(L) + 1;
                exp_bus.push_back(a);
                r.found = 1'b1; r.nonce = nonce; r.at = rl + 2 * int'(L) + 2;
            end else begin
                r.found = 1'b0; r.nonce = 32'h0; r.at = rl + int'(L) + 1;
            end
            exp_res.push_back(r);
        end
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        chk("job_ready_busy", 64'(bus.job_ready), 64'd0);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && (exp_bus.size() != 0 || exp_res.size() != 0); i++)
            @(negedge clk);
        chk(name, 64'(exp_bus.size() + exp_res.size()), 64'd0);
        @(negedge clk);
        chk("idle_after_job", 64'({bus.busy, bus.job_ready, bus.result_valid}), 64'b010);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_strobes"}, 64'({bus.mst_chipselect, bus.mst_write, bus.mst_read}), 64'd0);
        chk({tag, "_addr"}, 64'(bus.mst_address), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.mst_writedata), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
        chk({tag, "_res"}, 64'({bus.result_valid, bus.result_found, bus.result_nonce}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run expected completion");
        $fatal(1);
    end

    int h;
    logic [255:0] t1, t2, t3;
    logic [607:0] m1, m2, m3;

    initial begin
        bus.job_valid  = 1'b0;
        bus.job_msg    = '0;
        bus.job_target = '0;
        bus.abort      = 1'b0;
        t1 = 256'h0000FFFF << 224;
        m1 = mk_msg(32'h0, 32'h1);
        t2 = mk_tgt(32'h1111_1111, 32'h1111_1111);
        m2 = mk_msg(32'h1000_0000, 32'h0003_0005);
        t3 = mk_tgt(32'hA5A5_0000, 32'h0000_0101);
        m3 = mk_msg(32'hFFFF_FFF0, 32'h0100_0001);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Abort in IDLE has no effect
        bus.abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ready", 64'({bus.job_ready, bus.busy}), 64'b10);
        bus.abort = 1'b0;

        // Job 1: two incomplete polls then found
        resp_q = '{32'h0, 32'h0, 32'h3, 32'h0000_1A2B};
        start_job(t1, m1, 30, 3, 1'b1, 32'h0000_1A2B, h);
        wait_done("job1_done");
        chk("job1_hold", 64'({bus.result_found, bus.result_nonce}), {31'd0, 1'b1, 32'h0000_1A2B});

        // Job 2: reserved status bits, complete without find; offers during busy ignored
        resp_q = '{32'hFFFF_FFF0, 32'hABCD_0002};
        start_job(t2, m2, 30, 2, 1'b0, 32'h0, h);
        bus.job_msg   = m3;
        bus.job_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_offer_ready", 64'({bus.job_ready, bus.busy}), 64'b01);
        end
        bus.job_valid = 1'b0;
        wait_done("job2_done");
        chk("job2_hold", 64'({bus.result_found, bus.result_nonce}), 64'd0);

        // Job 3: abort during the 15th write
        resp_q = {};
        start_job(t3, m3, 15, 0, 1'b0, 32'h0, h);
        repeat (14) @(negedge clk);
        chk("abort_cycle", 64'(cyc), 64'(h + 15));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_strobes", 64'({bus.mst_chipselect, bus.mst_write, bus.mst_read}), 64'd0);
        chk("abort_idle", 64'({bus.busy, bus.job_ready, bus.result_valid}), 64'b010);
        chk("abort_writes_seen", 64'(exp_bus.size()), 64'd0);
        repeat (5) @(negedge clk);

        // Job 4: found bit without complete keeps polling
        resp_q = '{32'h1, 32'hF0F0_F0F3, 32'hCAFE_F00D};
        start_job(t3, m3, 30, 2, 1'b1, 32'hCAFE_F00D, h);
        wait_done("job4_done");

        // Job 5: reset pulsed in POLL_WAIT
        resp_q = {};
        start_job(t1, m2, 30, 0, 1'b0, 32'h0, h);
        repeat (30) @(negedge clk);
        chk("poll_wait_quiet", 64'({bus.busy, bus.mst_chipselect}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midjob_reset");
        repeat (6) @(negedge clk);
        chk("final_queues", 64'(exp_bus.size() + exp_res.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miner_job_master.md
MINER_JOB_MASTER -- requirements
Module: miner_job_master

Interface
REQ-001 Parameter POLL_GAP, default 16: idle cycles between consecutive status reads (range 1..255).
REQ-002 Parameter RD_LAT, default 1: cycles from read-strobe cycle to valid mst_readdata (range 1..3).
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 job_valid  in  1  job offered.
REQ-006 job_ready  out  1  block can accept a job.
REQ-007 job_msg  in  608  block-header message, bits [31:0] = word 0.
REQ-008 job_target  in  256  difficulty target, bits [31:0] = word 0.
REQ-009 abort  in  1  cancel current job.
REQ-010 mst_address  out  5  miner slave register address.
REQ-011 mst_writedata  out  32  write data.
REQ-012 mst_write, mst_read, mst_chipselect  out  1 each  bus strobes.
REQ-013 mst_readdata  in  32  read data from miner slave.
REQ-014 busy  out  1  job in progress.
REQ-015 result_valid  out  1  one-cycle result pulse.
REQ-016 result_found  out  1  nonce found (meaningful when result_valid).
REQ-017 result_nonce  out  32  winning nonce, 0 when not found.

Function
REQ-018 Register map: 1 = control (bit0 newTarget, bit1 newMsg); 2..9 = target words 0..7; 11..29 = message words 0..18; 30 = read nonce; 31 = read status (bit0 found, bit1 complete).
REQ-019 States: IDLE, WR_TGT, WR_MSG, CTRL0, CTRL1, CTRL3, POLL_WAIT, RD_STAT, STAT_WAIT, RD_NONCE, NONCE_WAIT, REPORT.
REQ-020 job_ready = 1 only in IDLE; job captured into internal registers on clk when job_valid && job_ready; next state WR_TGT.
REQ-021 Each bus access is exactly one cycle with mst_chipselect = 1 and exactly one of mst_write/mst_read = 1; no waitrequest; strobes 0 in all non-access cycles.
REQ-022 WR_TGT: 8 consecutive writes, addresses 2..9, data target words 0..7; then WR_MSG.
REQ-023 WR_MSG: 19 consecutive writes, addresses 11..29, data message words 0..18; then CTRL0.
REQ-024 CTRL0, CTRL1, CTRL3: one write each to address 1 with data 0, 1, 3 (rising edges on newTarget, then newMsg); then POLL_WAIT.
REQ-025 First bus write occurs the cycle after job acceptance; the 30 writes occupy 30 consecutive cycles.
REQ-026 POLL_WAIT: gap counter counts POLL_GAP cycles with no access, then RD_STAT.
REQ-027 RD_STAT: one read of address 31; STAT_WAIT holds RD_LAT cycles, samples mst_readdata in the final one.
REQ-028 Status complete = 0 -> POLL_WAIT (counter reloaded); complete = 1, found = 0 -> REPORT with nonce 0; complete = 1, found = 1 -> RD_NONCE.
REQ-029 RD_NONCE: one read of address 30; NONCE_WAIT samples after RD_LAT cycles into result_nonce; then REPORT.
REQ-030 REPORT: result_valid = 1 for exactly one cycle, result_found/result_nonce held stable until next REPORT; next state IDLE.
REQ-031 busy = 1 in every state except IDLE.
REQ-032 abort = 1 in any non-IDLE state: next state IDLE, no access that cycle onward, no result_valid; abort in IDLE ignored; abort wins over all other transitions in the same cycle.
REQ-033 job_valid during busy ignored (job_ready = 0); a new job after abort restarts from WR_TGT, including control 0/1/3 sequence.
REQ-034 Status reads with reserved bits set: only bits 1:0 interpreted.

Reset
REQ-035 rst = 1 at a clk edge: state IDLE, all counters 0, mst_* strobes 0, mst_address 0, mst_writedata 0, result_valid 0, result_found 0, result_nonce 0, busy 0; job_ready 1 from first cycle after reset deasserts.
REQ-036 rst mid-job overrides abort and all transitions; no partial access completes after the reset edge.

Verification
REQ-037 Job (target = 256'h0000FFFF<<224, msg words = index) -> writes addr 2..9 then 11..29 then 1 with 0,1,3 on 30 consecutive cycles, first one cycle after handshake.
REQ-038 Slave model returns status 0 twice, then 3, nonce 32'h0000_1A2B -> three status reads POLL_GAP apart, one nonce read, result_valid pulse with found = 1, nonce 32'h0000_1A2B.
REQ-039 Status 2 (complete, not found) -> no address-30 read; result_valid, found = 0, nonce = 0.
REQ-040 abort asserted on 15th write -> strobes 0 next cycle, busy 0, no result_valid; next job full 30-write sequence.
REQ-041 RD_LAT = 3, POLL_GAP = 1 -> status sampled 3 cycles after read strobe; exactly one idle cycle between status reads.
REQ-042 rst pulsed during POLL_WAIT -> all outputs reset values next cycle, job_ready = 1.
